instr_mem_loader: RTL

INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

---
 rtl/instr_mem_loader.sv | 106 ++++++++++
 1 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: byte-stream program loader into a word memory with a registered CPU fetch port.
// Ports:
//   clk, rst_n              - clock, asynchronous active-low reset
//   load_start, load_len    - begin a load of load_len words (saturated to DEPTH)
//   load_abort              - cancel a load in progress
//   ld_data, ld_valid       - incoming byte stream, big-endian within each word
//   ld_ready                - a byte is accepted this cycle when ld_valid is also high
//   load_busy, load_done    - load in progress / one-cycle completion pulse
//   fetch_en, fetch_addr    - CPU read request, served only while idle
//   fetch_data, fetch_valid - read data one cycle after an accepted request
module instr_mem_loader #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              load_abort,
   input  logic [7:0]        ld_data,
   input  logic              ld_valid,
   output logic              ld_ready,
   output logic              load_busy,
   output logic              load_done,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic [DATA_W-1:0] fetch_data,
   output logic              fetch_valid
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int BPW   = DATA_W / 8;
   localparam int BC_W  = (BPW > 1) ? $clog2(BPW) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t              state_q;
   logic [ADDR_W-1:0]   wr_addr_q;
   logic [ADDR_W:0]     word_cnt_q, len_q, len_d;
   logic [BC_W-1:0]     byte_cnt_q;
   logic [DATA_W-1:0]   word_q, word_d, fetch_data_q;
   logic                fetch_valid_q, accept, last_byte, last_word, wr_en;
   logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

   assign ld_ready    = state_q == LOAD;
   assign load_busy   = state_q != IDLE;
   assign load_done   = state_q == DONE;
   assign fetch_data  = fetch_data_q;
   assign fetch_valid = fetch_valid_q;

   always_comb begin
      accept    = (state_q == LOAD) && ld_valid;
      last_byte = byte_cnt_q == BC_W'(BPW - 1);
      last_word = (word_cnt_q + (ADDR_W + 1)'(1)) == len_q;
      // shifting left by a byte puts the first byte of a word in the top bits
      word_d    = DATA_W'({word_q, ld_data});
      // abort wins over a completing byte, so the final word is dropped
      wr_en     = accept && last_byte && !load_abort;
      len_d     = (load_len > (ADDR_W + 1)'(DEPTH)) ? (ADDR_W + 1)'(DEPTH) : load_len;
   end

   // memory is deliberately outside the reset domain so loaded words survive reset
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr_q] <= word_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         wr_addr_q     <= '0;
         word_cnt_q    <= '0;
         byte_cnt_q    <= '0;
         len_q         <= '0;
         word_q        <= '0;
         fetch_data_q  <= '0;
         fetch_valid_q <= 1'b0;
      end else begin
         fetch_valid_q <= (state_q == IDLE) && fetch_en;
         if ((state_q == IDLE) && fetch_en) fetch_data_q <= mem[fetch_addr];
         case (state_q)
            IDLE: begin
               if (load_start) begin
                  state_q    <= (load_len == '0) ? DONE : LOAD;
                  wr_addr_q  <= '0;
                  word_cnt_q <= '0;
                  byte_cnt_q <= '0;
                  len_q      <= len_d;
               end
            end
            LOAD: begin
               if (load_abort) begin
                  state_q <= IDLE;
               end else if (accept) begin
                  word_q     <= word_d;
                  byte_cnt_q <= last_byte ? '0 : byte_cnt_q + BC_W'(1);
                  if (last_byte) begin
                     wr_addr_q  <= wr_addr_q + ADDR_W'(1);
                     word_cnt_q <= word_cnt_q + (ADDR_W + 1)'(1);
                     if (last_word) state_q <= DONE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule
